// File: rtl/waveform_ctrl_if.sv
// waveform_ctrl_if: host load, lookup and RAM port A signals of the waveform controller
interface waveform_ctrl_if #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
);
  logic             ld_start;
  logic [DBITS-1:0] ld_csum;
  logic             ld_valid;
  logic [DBITS-1:0] ld_data;
  logic             ld_ready;
  logic             ld_done;
  logic             ld_err;
  logic             swap_pend;
  logic             frame_start;
  logic             active_bank;
  logic             rd_req;
  logic [ABITS-2:0] rd_addr;
  logic             rd_valid;
  logic [DBITS-1:0] rd_data;
  logic             ram_we;
  logic [ABITS-1:0] ram_addr;
  logic [DBITS-1:0] ram_din;
  logic [DBITS-1:0] ram_dout;
  modport master (
    output ld_start, ld_csum, ld_valid, ld_data, frame_start, rd_req, rd_addr, ram_dout,
    input  ld_ready, ld_done, ld_err, swap_pend, active_bank, rd_valid, rd_data,
           ram_we, ram_addr, ram_din
  );
  modport slave (
    input  ld_start, ld_csum, ld_valid, ld_data, frame_start, rd_req, rd_addr, ram_dout,
    output ld_ready, ld_done, ld_err, swap_pend, active_bank, rd_valid, rd_data,
           ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/waveform_ctrl.sv
// waveform_ctrl: double-buffered waveform table loader with checksum and lookup-priority RAM arbitration
module waveform_ctrl #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
) (
  input logic           clk,
  input logic           rst,
  waveform_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, PEND} state_t;
  state_t           state;
  logic [ABITS-2:0] wr_ptr;
  logic [DBITS-1:0] sum;
  logic [DBITS-1:0] csum_q;
  logic [DBITS-1:0] sum_nxt;
  logic             active_bank;
  logic             swap_pend;
  logic             ld_done;
  logic             ld_err;
  logic             rd_valid;
  logic             acc;
  // a host write is taken only in LOAD and only when no lookup claims the port
  always_comb begin
    acc     = (state == LOAD) && bus.ld_valid && !bus.rd_req;
    sum_nxt = sum + bus.ld_data;
  end
  assign bus.ld_ready    = (state == LOAD) && !bus.rd_req;
  assign bus.ram_we      = acc;
  assign bus.ram_addr    = acc ? {~active_bank, wr_ptr} : {active_bank, bus.rd_addr};
  assign bus.ram_din     = bus.ld_data;
  assign bus.rd_data     = bus.ram_dout;
  assign bus.rd_valid    = rd_valid;
  assign bus.active_bank = active_bank;
  assign bus.swap_pend   = swap_pend;
  assign bus.ld_done     = ld_done;
  assign bus.ld_err      = ld_err;
  // load sequencer; ld_start restarts from any state except the one-cycle CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      sum         <= '0;
      csum_q      <= '0;
      active_bank <= 1'b0;
      swap_pend   <= 1'b0;
      ld_done     <= 1'b0;
      ld_err      <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= bus.rd_req;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      if (bus.ld_start && state != CHECK) begin
        state     <= LOAD;
        wr_ptr    <= '0;
        sum       <= '0;
        csum_q    <= bus.ld_csum;
        swap_pend <= 1'b0;
      end else begin
        case (state)
          LOAD: if (acc) begin
            wr_ptr <= wr_ptr + 1'b1;
            sum    <= sum_nxt;
            if (&wr_ptr) begin
              state   <= CHECK;
              ld_done <= sum_nxt == csum_q;
              ld_err  <= sum_nxt != csum_q;
            end
          end
          CHECK: begin
            state     <= (sum == csum_q) ? PEND : IDLE;
            swap_pend <= sum == csum_q;
          end
          PEND: if (bus.frame_start) begin
            state       <= IDLE;
            active_bank <= ~active_bank;
            swap_pend   <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_waveform_ctrl.sv
// tb_waveform_ctrl: directed checks of load, checksum, swap and lookup arbitration with ABITS=4
module tb_waveform_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic exp_bank = 1'b0;
  logic [7:0] mem [16];
  always #5 clk = ~clk;
  waveform_ctrl_if #(.ABITS(4), .DBITS(8)) bus();
  waveform_ctrl #(.ABITS(4), .DBITS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  // port A model: registered read that holds on write cycles
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    else bus.ram_dout <= mem[bus.ram_addr];
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic st, input logic [7:0] cs, input logic v, input logic [7:0] d,
                      input logic fs, input logic rq, input logic [2:0] ra);
    @(negedge clk);
    bus.ld_start = st; bus.ld_csum = cs; bus.ld_valid = v; bus.ld_data = d;
    bus.frame_start = fs; bus.rd_req = rq; bus.rd_addr = ra;
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [3:0] a);
    step(0, 0, 1, d, 0, 0, 0);
    check("wr_ready", bus.ld_ready, 1);
    check("wr_we", bus.ram_we, 1);
    check("wr_addr", bus.ram_addr, a);
    check("wr_din", bus.ram_din, d);
  endtask
  task automatic stall(input logic [7:0] d, input logic [2:0] ra, input logic first);
    step(0, 0, 1, d, 0, 1, ra);
    check("stall_ready", bus.ld_ready, 0);
    check("stall_we", bus.ram_we, 0);
    check("stall_addr", bus.ram_addr, {exp_bank, ra});
    if (!first) check("stall_rd_valid", bus.rd_valid, 1);
  endtask
  task automatic finish_load(input logic ok);
    step(0, 0, 0, 0, 0, 0, 0);
    check("ld_done", bus.ld_done, ok);
    check("ld_err", bus.ld_err, !ok);
    check("pend_early", bus.swap_pend, 0);
    check("idle_we", bus.ram_we, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("swap_pend", bus.swap_pend, ok);
    check("done_pulse", bus.ld_done, 0);
    check("err_pulse", bus.ld_err, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? 8'hA0 + 8'(i) : 8'h55;
    bus.ld_start = 0; bus.ld_csum = 0; bus.ld_valid = 0; bus.ld_data = 0;
    bus.frame_start = 0; bus.rd_req = 0; bus.rd_addr = 0;
    #12;
    check("rst_bank", bus.active_bank, 0);
    check("rst_pend", bus.swap_pend, 0);
    check("rst_ready", bus.ld_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.ld_done, 0);
    check("rst_err", bus.ld_err, 0);
    check("rst_we", bus.ram_we, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 3);
      check("rd_addr", bus.ram_addr, 3);
      check("rd_we", bus.ram_we, 0);
      check("rd_valid", bus.rd_valid, i > 0);
      if (i > 0) check("rd_data", bus.rd_data, 8'hA3);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("rd_valid_last", bus.rd_valid, 1);
    check("rd_data_last", bus.rd_data, 8'hA3);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rd_valid_off", bus.rd_valid, 0);
    step(1, 8'h24, 0, 0, 0, 0, 0);
    check("idle_ready", bus.ld_ready, 0);
    for (int i = 1; i <= 3; i++) send(8'(i), 4'(7 + i));
    for (int i = 0; i < 3; i++) stall(8'd4, 3'd1, i == 0);
    check("stall_rd_data", bus.rd_data, 8'hA1);
    for (int i = 4; i <= 8; i++) send(8'(i), 4'(7 + i));
    finish_load(1);
    step(0, 0, 0, 0, 1, 1, 2);
    check("swap_old_addr", bus.ram_addr, 2);
    exp_bank = 1;
    step(0, 0, 0, 0, 0, 1, 2);
    check("swap_bank", bus.active_bank, exp_bank);
    check("swap_pend_clr", bus.swap_pend, 0);
    check("swap_old_data", bus.rd_data, 8'hA2);
    check("swap_new_addr", bus.ram_addr, 10);
    step(0, 0, 0, 0, 0, 0, 0);
    check("swap_new_data", bus.rd_data, 8'h03);
    @(negedge clk) rst = 1;
    exp_bank = 0;
    #1 check("rst2_bank", bus.active_bank, exp_bank);
    @(negedge clk) rst = 0;
    step(1, 8'h25, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) send(8'(i), 4'(7 + i));
    finish_load(0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("bad_bank", bus.active_bank, exp_bank);
    check("bad_pend", bus.swap_pend, 0);
    check("bad_ready", bus.ld_ready, 0);
    step(1, 8'h77, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 4'(8 + i));
    step(1, 8'h1C, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 4'(8 + i));
    finish_load(1);
    step(1, 8'h24, 0, 0, 1, 0, 0);
    check("tie_pend_before", bus.swap_pend, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("tie_bank", bus.active_bank, exp_bank);
    check("tie_pend", bus.swap_pend, 0);
    check("tie_load", bus.ld_ready, 1);
    for (int i = 1; i <= 8; i++) send(8'(i), 4'(7 + i));
    finish_load(1);
    step(0, 0, 0, 0, 1, 0, 0);
    exp_bank = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    check("swap2_bank", bus.active_bank, exp_bank);
    step(1, 8'h24, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) send(8'(i), 4'(i - 1));
    finish_load(1);
    @(negedge clk) rst = 1;
    exp_bank = 0;
    #1;
    check("pend_rst_bank", bus.active_bank, exp_bank);
    check("pend_rst_pend", bus.swap_pend, 0);
    check("pend_rst_ready", bus.ld_ready, 0);
    @(negedge clk) rst = 0;
    step(0, 0, 0, 0, 0, 1, 2);
    check("bank0_addr", bus.ram_addr, 2);
    step(0, 0, 0, 0, 0, 0, 0);
    check("bank0_data", bus.rd_data, 8'h03);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
